// File: rtl/io_bus_master_if.sv
// io_bus_master_if
//   Bundles the command/response handshake and the peripheral I/O bus of the
//   word-addressed bus master.
//   Command : Cmd_Valid, Cmd_Ready, Cmd_Write, Cmd_Add[5:0] (word addr [7:2]), Cmd_WData
//   Response: Rsp_Valid, Rsp_Ready, Rsp_RData, Rsp_Err
//   Bus     : Add[5:0], Sel, Write, DOut (to peripheral), DIn, Ack (from peripheral)
//   modport master : view of the bus master itself
//   modport slave  : view of the command source, response sink and peripheral
interface io_bus_master_if #(
   parameter int DW = 32
);
   logic          Cmd_Valid;
   logic          Cmd_Ready;
   logic          Cmd_Write;
   logic [5:0]    Cmd_Add;
   logic [DW-1:0] Cmd_WData;
   logic          Rsp_Valid;
   logic          Rsp_Ready;
   logic [DW-1:0] Rsp_RData;
   logic          Rsp_Err;
   logic [5:0]    Add;
   logic          Sel;
   logic          Write;
   logic [DW-1:0] DOut;
   logic [DW-1:0] DIn;
   logic          Ack;

   modport master (
      input  Cmd_Valid, Cmd_Write, Cmd_Add, Cmd_WData, Rsp_Ready, DIn, Ack,
      output Cmd_Ready, Rsp_Valid, Rsp_RData, Rsp_Err, Add, Sel, Write, DOut
   );

   modport slave (
      output Cmd_Valid, Cmd_Write, Cmd_Add, Cmd_WData, Rsp_Ready, DIn, Ack,
      input  Cmd_Ready, Rsp_Valid, Rsp_RData, Rsp_Err, Add, Sel, Write, DOut
   );
endinterface

// File: rtl/io_bus_master.sv
// io_bus_master
//   Initiator of the word-addressed peripheral I/O bus. Takes one read or
//   write command at a time, runs a SETUP cycle followed by ACCESS cycles
//   until the peripheral acknowledges or the wait budget runs out, then
//   presents the result on the response port.
//   Ports:
//     clk_i   : system clock, rising edge
//     rst_n_i : asynchronous active-low reset
//     bus     : io_bus_master_if.master (command, response and bus signals)
//   Parameters:
//     DW      : data width
//     TIMEOUT : ACCESS cycles without Ack before an error response (1..255)
module io_bus_master #(
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input logic             clk_i,
   input logic             rst_n_i,
   io_bus_master_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // Counter value on the last ACCESS cycle allowed before timing out
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          wr_q, wr_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          sel_q, sel_d;
   logic          write_q, write_d;
   logic [5:0]    add_q, add_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic          cmd_accept_s;
   logic          rsp_done_s;
   logic          timeout_s;

   assign cmd_accept_s = bus.Cmd_Valid & cmd_ready_q;
   assign rsp_done_s   = rsp_valid_q & bus.Rsp_Ready;
   assign timeout_s    = (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_accept_s) state_d = ST_SETUP;
            else              state_d = ST_IDLE;
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // Ack takes priority over the final timeout cycle
            if (bus.Ack)        state_d = ST_RESP;
            else if (timeout_s) state_d = ST_RESP;
            else                state_d = ST_ACCESS;
         end
         ST_RESP: begin
            if (rsp_done_s) state_d = ST_IDLE;
            else            state_d = ST_RESP;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs and datapath, computed one cycle
   // ahead so every bus/response output comes straight from a flop
   always_comb begin
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      cmd_ready_d = cmd_ready_q;
      sel_d       = sel_q;
      write_d     = write_q;
      add_d       = add_q;
      dout_d      = dout_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_accept_s) begin
               wr_d        = bus.Cmd_Write;
               add_d       = bus.Cmd_Add;
               dout_d      = bus.Cmd_Write ? bus.Cmd_WData : {DW{1'b0}};
               cmd_ready_d = 1'b0;
               sel_d       = 1'b1;
               write_d     = 1'b0;
            end else begin
               cmd_ready_d = 1'b1;
            end
         end
         ST_SETUP: begin
            cnt_d   = 8'd0;
            write_d = wr_q;
         end
         ST_ACCESS: begin
            if (bus.Ack) begin
               sel_d       = 1'b0;
               write_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = wr_q ? {DW{1'b0}} : bus.DIn;
               rsp_err_d   = 1'b0;
            end else if (timeout_s) begin
               sel_d       = 1'b0;
               write_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = {DW{1'b0}};
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            if (rsp_done_s) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            cmd_ready_d = 1'b1;
            sel_d       = 1'b0;
            write_d     = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_q        <= 1'b0;
         cnt_q       <= 8'd0;
         cmd_ready_q <= 1'b1;
         sel_q       <= 1'b0;
         write_q     <= 1'b0;
         add_q       <= 6'd0;
         dout_q      <= {DW{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {DW{1'b0}};
         rsp_err_q   <= 1'b0;
      end else begin
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         sel_q       <= sel_d;
         write_q     <= write_d;
         add_q       <= add_d;
         dout_q      <= dout_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.Cmd_Ready = cmd_ready_q;
   assign bus.Sel       = sel_q;
   assign bus.Write     = write_q;
   assign bus.Add       = add_q;
   assign bus.DOut      = dout_q;
   assign bus.Rsp_Valid = rsp_valid_q;
   assign bus.Rsp_RData = rsp_rdata_q;
   assign bus.Rsp_Err   = rsp_err_q;

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master
//   Directed and randomized transactions against io_bus_master. The expected
//   cycle-by-cycle bus view and the response are derived per command from the
//   protocol rules: SETUP one cycle after acceptance, ACCESS lasts
//   min(ack_delay+1, TIMEOUT) cycles, response follows, handshake returns to idle.
module tb_io_bus_master;

   localparam int DW = 32;
   localparam int TO = 15;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   io_bus_master_if #(.DW(DW)) bus ();

   io_bus_master #(.DW(DW), .TIMEOUT(TO)) u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One complete command: drives command, peripheral and response sides and
   // checks every cycle against the expected timeline. delay >= TO means no Ack.
   task automatic run_cmd(input logic wr, input logic [5:0] add, input logic [DW-1:0] wdata,
                          input int delay, input logic [DW-1:0] din, input int stall,
                          input bit stray, input bit pre, input bit hold_next,
                          input logic nwr, input logic [5:0] nadd, input logic [DW-1:0] nwdata);
      int            access_n, rsp_c, hs_c;
      logic [DW-1:0] exp_dout, exp_rdata;
      logic          exp_err, exp_sel, exp_write, exp_rv, exp_ready;
      access_n  = (delay < TO) ? delay + 1 : TO;
      rsp_c     = 2 + access_n;
      hs_c      = rsp_c + stall;
      exp_dout  = wr ? wdata : '0;
      exp_err   = (delay >= TO);
      exp_rdata = (wr || exp_err) ? '0 : din;
      if (!pre) begin
         @(negedge clk);
         vectors++;
         if (bus.Cmd_Ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_ready_idle got %b want 1", bus.Cmd_Ready);
         end
         bus.Cmd_Valid = 1'b1;
         bus.Cmd_Write = wr;
         bus.Cmd_Add   = add;
         bus.Cmd_WData = wdata;
         bus.Ack       = 1'b0;
      end
      for (int c = 1; c <= hs_c + 1; c++) begin
         @(negedge clk);
         exp_sel   = (c < rsp_c);
         exp_write = wr && (c >= 2) && (c < rsp_c);
         exp_rv    = (c >= rsp_c) && (c <= hs_c);
         exp_ready = (c == hs_c + 1);
         vectors += 4;
         if (bus.Sel !== exp_sel) begin
            miscompares++;
            $display("FAIL sel c=%0d got %b want %b", c, bus.Sel, exp_sel);
         end
         if (bus.Write !== exp_write) begin
            miscompares++;
            $display("FAIL write c=%0d got %b want %b", c, bus.Write, exp_write);
         end
         if (bus.Rsp_Valid !== exp_rv) begin
            miscompares++;
            $display("FAIL rsp_valid c=%0d got %b want %b", c, bus.Rsp_Valid, exp_rv);
         end
         if (bus.Cmd_Ready !== exp_ready) begin
            miscompares++;
            $display("FAIL cmd_ready c=%0d got %b want %b", c, bus.Cmd_Ready, exp_ready);
         end
         if (exp_sel) begin
            vectors += 2;
            if (bus.Add !== add) begin
               miscompares++;
               $display("FAIL add c=%0d got %h want %h", c, bus.Add, add);
            end
            if (bus.DOut !== exp_dout) begin
               miscompares++;
               $display("FAIL dout c=%0d got %h want %h", c, bus.DOut, exp_dout);
            end
         end
         if (c >= rsp_c) begin
            vectors += 2;
            if (bus.Rsp_RData !== exp_rdata) begin
               miscompares++;
               $display("FAIL rsp_rdata c=%0d got %h want %h", c, bus.Rsp_RData, exp_rdata);
            end
            if (bus.Rsp_Err !== exp_err) begin
               miscompares++;
               $display("FAIL rsp_err c=%0d got %b want %b", c, bus.Rsp_Err, exp_err);
            end
         end
         // command side: garbage while busy, must be ignored
         bus.Cmd_Valid = (stray && c <= hs_c) ? 1'($urandom) : 1'b0;
         bus.Cmd_Write = 1'($urandom);
         bus.Cmd_Add   = 6'($urandom);
         bus.Cmd_WData = $urandom;
         if (hold_next && c >= rsp_c) begin
            bus.Cmd_Valid = 1'b1;
            bus.Cmd_Write = nwr;
            bus.Cmd_Add   = nadd;
            bus.Cmd_WData = nwdata;
         end
         // peripheral side
         if (c >= 2 && c < rsp_c) begin
            bus.Ack = (c == 2 + delay);
            bus.DIn = (c == 2 + delay) ? din : $urandom;
         end else begin
            bus.Ack = stray ? 1'($urandom) : 1'b0;
            bus.DIn = $urandom;
         end
         // response side
         if (c < rsp_c)        bus.Rsp_Ready = 1'($urandom);
         else if (c < hs_c)    bus.Rsp_Ready = 1'b0;
         else if (c == hs_c)   bus.Rsp_Ready = 1'b1;
         else                  bus.Rsp_Ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.Cmd_Valid = 1'b0;
      bus.Cmd_Write = 1'b0;
      bus.Cmd_Add   = 6'd0;
      bus.Cmd_WData = '0;
      bus.Rsp_Ready = 1'b0;
      bus.DIn       = '0;
      bus.Ack       = 1'b0;
      #12;
      vectors += 8;
      if (bus.Cmd_Ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 1", bus.Cmd_Ready); end
      if (bus.Sel !== 1'b0)       begin miscompares++; $display("FAIL reset_sel got %b want 0", bus.Sel); end
      if (bus.Write !== 1'b0)     begin miscompares++; $display("FAIL reset_write got %b want 0", bus.Write); end
      if (bus.Rsp_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", bus.Rsp_Valid); end
      if (bus.Rsp_Err !== 1'b0)   begin miscompares++; $display("FAIL reset_rsp_err got %b want 0", bus.Rsp_Err); end
      if (bus.Rsp_RData !== '0)   begin miscompares++; $display("FAIL reset_rsp_rdata got %h want 0", bus.Rsp_RData); end
      if (bus.Add !== 6'd0)       begin miscompares++; $display("FAIL reset_add got %h want 0", bus.Add); end
      if (bus.DOut !== '0)        begin miscompares++; $display("FAIL reset_dout got %h want 0", bus.DOut); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      run_cmd(1'b1, 6'b001100, 32'h3, 0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
   endtask

   task automatic test_read_wait();
      run_cmd(1'b0, 6'b001000, 32'hFFFF_FFFF, 3, 32'h0000_00A5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
   endtask

   task automatic test_timeout();
      run_cmd(1'b0, 6'h15, 32'h0, 1000, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
      run_cmd(1'b1, 6'h2C, 32'h1234_5678, 1, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
   endtask

   task automatic test_ack_last();
      run_cmd(1'b0, 6'h3F, 32'h0, TO - 1, 32'hCAFE_F00D, 2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, '0);
   endtask

   task automatic test_back_to_back();
      run_cmd(1'b1, 6'h07, 32'hA5A5_0001, 2, 32'h0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 6'h2A, 32'h0);
      run_cmd(1'b0, 6'h2A, 32'h0, 0, 32'h5555_AAAA, 0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, '0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.Cmd_Valid = 1'b1;
      bus.Cmd_Write = 1'b1;
      bus.Cmd_Add   = 6'h11;
      bus.Cmd_WData = 32'h0BAD_CAFE;
      bus.Ack       = 1'b0;
      @(negedge clk);
      bus.Cmd_Valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.Write !== 1'b1) begin miscompares++; $display("FAIL pre_reset_write got %b want 1", bus.Write); end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors += 4;
      if (bus.Sel !== 1'b0)       begin miscompares++; $display("FAIL async_sel got %b want 0", bus.Sel); end
      if (bus.Write !== 1'b0)     begin miscompares++; $display("FAIL async_write got %b want 0", bus.Write); end
      if (bus.Rsp_Valid !== 1'b0) begin miscompares++; $display("FAIL async_rsp_valid got %b want 0", bus.Rsp_Valid); end
      if (bus.Cmd_Ready !== 1'b1) begin miscompares++; $display("FAIL async_cmd_ready got %b want 1", bus.Cmd_Ready); end
      bus.Ack = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.Ack = 1'($urandom);
         bus.Rsp_Ready = 1'($urandom);
         vectors += 2;
         if (bus.Rsp_Valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_rsp_valid i=%0d got %b want 0", i, bus.Rsp_Valid); end
         if (bus.Sel !== 1'b0)       begin miscompares++; $display("FAIL post_reset_sel i=%0d got %b want 0", i, bus.Sel); end
      end
      run_cmd(1'b0, 6'h19, 32'h0, 2, 32'h0000_7E57, 1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, '0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         run_cmd(1'($urandom), 6'($urandom), $urandom, int'($urandom_range(0, 20)), $urandom,
                 int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, '0);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_write();
      test_read_wait();
      test_timeout();
      test_ack_last();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Initiator (master) side of the word-addressed peripheral I/O bus: Add[7:2], Write, write data, read data and a peripheral Ack.
- Accepts one read or write command at a time from a command port and runs the bus cycle with wait-state support and a timeout.
- Returns read data or write completion on a response port.
- Sits between the processor/test sequencer and the memory-mapped peripherals, such as the switch/LED register block.

Parameters:
- DW, 32, data bus width in bits.
- TIMEOUT, 15, maximum cycles spent in ACCESS without Ack before error completion. Legal range 1..255.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  master can accept a command.
- Cmd_Write  in  1  1 = write, 0 = read.
- Cmd_Add  in  6  word address [7:2].
- Cmd_WData  in  DW  write data.
- Rsp_Valid  out  1  response present.
- Rsp_Ready  in  1  consumer accepts the response.
- Rsp_RData  out  DW  read data; 0 for writes and errors.
- Rsp_Err  out  1  timeout occurred.
- Add  out  6  bus word address [7:2].
- Sel  out  1  bus cycle active.
- Write  out  1  bus write strobe.
- DOut  out  DW  bus write data.
- DIn  in  DW  bus read data from the peripheral.
- Ack  in  1  peripheral completes the access.

Behaviour:
- Reset values (Reset_n low, asynchronous): state IDLE, Cmd_Ready=1, all other outputs 0, timeout counter 0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Cmd_Ready=1; Sel=0; Write=0.
  - On Cmd_Valid&Cmd_Ready: latch Cmd_Write, Cmd_Add and Cmd_WData; go to SETUP.
- SETUP (1 cycle):
  - Cmd_Ready=0.
  - Add and DOut driven from the latched values; DOut=0 for reads.
  - Sel=1, Write=0.
  - Clear the timeout counter; go to ACCESS.
- ACCESS:
  - Sel=1. Write=latched write flag, held high for every ACCESS cycle of a write.
  - Add and DOut stay stable.
  - Ack=1 sampled: read captures DIn into Rsp_RData, write sets Rsp_RData=0; Rsp_Err=0; go to RESP.
  - Ack=0 and counter==TIMEOUT-1: Rsp_Err=1, Rsp_RData=0, go to RESP.
  - Ack=0 otherwise: counter+1, stay in ACCESS.
  - Ack and the final timeout cycle together: Ack wins, no error.
- RESP:
  - Sel=0, Write=0, Rsp_Valid=1.
  - Rsp_RData and Rsp_Err hold until Rsp_Valid&Rsp_Ready.
  - On handshake: go to IDLE, Rsp_Valid=0 next cycle. Rsp_RData/Rsp_Err keep their values until the next response.
- Latency: command accepted at edge T; SETUP during T+1; ACCESS from T+2. Zero-wait Ack at T+2 gives Rsp_Valid high from T+3. Each wait state adds 1 cycle.
- Throughput: 1 outstanding command. The next command is accepted no earlier than the cycle after the response handshake. Cmd_Ready is registered; it rises in the cycle after returning to IDLE.
- Ack outside ACCESS is ignored. DIn is sampled only on the Ack cycle in ACCESS.
- Bus outputs are registered; Add and DOut keep their last values in IDLE/RESP, but Sel=0 marks them invalid.
- Reset_n asserted mid-cycle (any state): outputs return to reset values immediately; the in-flight command is dropped and no response is produced.

Test Plan:
1. Write Cmd_Add=6'b001100, Cmd_WData=0x3, Ack high on the first ACCESS cycle -> Sel=1 at T+1, Write=1 exactly 1 cycle (T+2), Add=6'b001100, DOut=0x3; Rsp_Valid at T+3 with Rsp_Err=0, Rsp_RData=0.
2. Read Cmd_Add=6'b001000, Ack after 3 wait states, DIn=0x000000A5 on the Ack cycle -> Write never high, Rsp_RData=0xA5, Rsp_Valid at T+6.
3. Read with Ack never asserted, TIMEOUT=15 -> exactly 15 ACCESS cycles, then Rsp_Valid=1, Rsp_Err=1, Rsp_RData=0; next command accepted normally.
4. Ack asserted on the 15th ACCESS cycle -> Rsp_Err=0, data captured; stray Ack pulses in IDLE/RESP have no effect.
5. Rsp_Ready held low 4 cycles after Rsp_Valid -> Rsp_Valid, Rsp_RData and Rsp_Err stable; Cmd_Ready stays 0 while a new Cmd_Valid is held. After the handshake the new command is accepted and Cmd_Ready=0 again.
6. Reset_n pulsed low during ACCESS of a write -> Sel, Write, Rsp_Valid=0 and Cmd_Ready=1 asynchronously, no response emitted; a subsequent read completes correctly.
